// File: rtl/conv_interleaver_param_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_interleaver_param_if
// Description : Streaming bus for the convolutional interleaver: control
//               (mode/sync), valid-qualified input symbols and registered
//               output symbols with commutator position and priming flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_interleaver_param_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic              mode;
  logic              sync;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  select;
  logic              primed;

  // Producer side: drives control and input symbols, observes the output.
  modport master (
    output mode, sync, in_valid, in_data,
    input  out_valid, out_data, select, primed
  );

  // Interleaver side.
  modport slave (
    input  mode, sync, in_valid, in_data,
    output out_valid, out_data, select, primed
  );
endinterface
`default_nettype wire

// File: rtl/conv_interleaver_param.sv
`default_nettype none
// ============================================================================
// Module      : conv_interleaver_param
// Description : Forney convolutional interleaver / deinterleaver with runtime
//               mode, commutator resync and priming flag. Branch b delays
//               b*STEP visits (interleave) or (B-1-b)*STEP visits
//               (deinterleave). Both modes share one bank of physical FIFOs
//               whose depths are p*STEP; deinterleave maps branch b onto
//               physical FIFO B-1-b.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_interleaver_param #(
  parameter int DATA_W   = 8,
  parameter int BRANCHES = 4,
  parameter int STEP     = 1,
  parameter int SEL_W    = $clog2(BRANCHES)
) (
  input  wire                       clk,
  input  wire                       reset,
  conv_interleaver_param_if.slave   bus
);

  // Accept index at which every branch has flushed its pre-sync contents.
  localparam int c_prime_idx = (BRANCHES - 1) * STEP * BRANCHES + (BRANCHES - 1);
  localparam int c_cnt_w     = $clog2(c_prime_idx + 1);

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [SEL_W-1:0]    r_select;
  logic                r_primed;
  logic [c_cnt_w-1:0]  r_acc_cnt;
  logic                r_mode;
  logic                r_boot;

  logic                w_accept;
  logic                w_mode;
  logic [SEL_W-1:0]    w_phys;
  logic [DATA_W-1:0]   w_tap [BRANCHES];

  // Until the first edge after reset release the mode input is used live,
  // so the register effectively samples it at release without needing an
  // asynchronous data load.
  assign w_mode   = r_boot ? bus.mode : r_mode;
  assign w_accept = bus.in_valid & ~bus.sync;
  assign w_phys   = w_mode ? (SEL_W'(BRANCHES - 1) - r_select) : r_select;

  // Physical FIFO 0 has no storage: the symbol passes straight through.
  assign w_tap[0] = bus.in_data;

  for (genvar p = 1; p < BRANCHES; p++) begin : g_branch
    localparam int c_depth = p * STEP;
    logic [DATA_W-1:0] r_cell [c_depth];

    // Shift one cell on every accept routed to this FIFO; the last cell is the oldest.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < c_depth; i++) begin
          r_cell[i] <= '0;
        end
      end else if (w_accept && (w_phys == SEL_W'(p))) begin
        r_cell[0] <= bus.in_data;
        for (int i = 1; i < c_depth; i++) begin
          r_cell[i] <= r_cell[i-1];
        end
      end
    end

    assign w_tap[p] = r_cell[c_depth-1];
  end

  // Mode register and the boot flag that hands mode over from the live input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= 1'b0;
      r_boot <= 1'b1;
    end else begin
      r_boot <= 1'b0;
      if (bus.sync || r_boot) begin
        r_mode <= bus.mode;
      end
    end
  end

  // Commutator, output register and priming counter; sync wins over valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_select    <= '0;
      r_primed    <= 1'b0;
      r_acc_cnt   <= '0;
    end else if (bus.sync) begin
      r_out_valid <= 1'b0;
      r_select    <= '0;
      r_primed    <= 1'b0;
      r_acc_cnt   <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_data <= w_tap[w_phys];
        r_select   <= (r_select == SEL_W'(BRANCHES - 1)) ? '0 : r_select + 1'b1;
        if (r_acc_cnt == c_cnt_w'(c_prime_idx)) begin
          r_primed <= 1'b1;
        end else begin
          r_acc_cnt <= r_acc_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.select    = r_select;
  assign bus.primed    = r_primed;

endmodule
`default_nettype wire

// File: doc/conv_interleaver_param.md
# conv_interleaver_param

Parametrised convolutional (Forney) interleaver/deinterleaver with a runtime mode select, valid qualification, commutator resync and a priming flag. One instance sits on the transmit side in interleave mode and a second sits on the receive side in deinterleave mode. The pair restores the original symbol order after a fixed end-to-end delay. The block supersedes the fixed 8-bit, fixed-branch interleaver/deinterleaver pair.

## Interface
- `DATA_W`, default 8: symbol width in bits.
- `BRANCHES`, default 4: commutator branch count B, with 2 ≤ B ≤ 16.
- `STEP`, default 1: delay increment S between adjacent branches, in branch visits, with S ≥ 1.
- `SEL_W`, default `$clog2(BRANCHES)`: width of `select`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mode` input 1: 0 selects interleave, 1 selects deinterleave. Sampled only at reset release and on `sync`.
- `sync` input 1: single-cycle pulse that restarts the commutator.
- `in_valid` input 1: qualifies `in_data`.
- `in_data` input DATA_W: input symbol.
- `out_valid` output 1: qualifies `out_data`.
- `out_data` output DATA_W: output symbol.
- `select` output SEL_W: branch that the next accepted symbol will use.
- `primed` output 1: high when every branch is emitting post-sync data.

## Operation
- **Branch delays** are counted in visits to that branch. For branch b:
  - Interleave mode: d_b = b·S.
  - Deinterleave mode: d_b = (B−1−b)·S.
- **Storage**: one FIFO per branch, each d_b cells deep, for a total of S·B·(B−1)/2 cells of DATA_W bits. A branch with d_b = 0 has no storage and passes the symbol straight through.
- **Accept**: a symbol is accepted on a rising edge where `in_valid` = 1 and `sync` = 0. On accept:
  - the symbol is pushed into branch `select`;
  - that branch's oldest cell is popped to the output register;
  - `select` advances by one, wrapping from B−1 to 0.
- **Stall**: with `in_valid` = 0, `select`, the FIFOs and the accept counter hold their values.
- **Sync**: a `sync` pulse has priority over `in_valid`. It drops the symbol presented in that cycle and:
  - sets `select` to 0 and latches `mode` into the internal mode register;
  - clears `primed` and the accept counter;
  - leaves FIFO contents unchanged. Stale data may therefore appear at the output until `primed` is high.
- **Accept counter**: counts accepted symbols since reset or sync and saturates at P = (B−1)·S·B + (B−1). `primed` goes high with the `out_valid` of accepted symbol index P (0-based) and stays high until the next reset or sync. The same P applies to both modes.
- **Cascade**: an interleave instance driving a deinterleave instance with identical parameters, both synced together, gives `out_data[n] = in_data[n − (B−1)·S·B]` with order preserved.

## Timing
- Latency from an accepted input to `out_valid` is 1 cycle; `out_valid` is registered.
- `out_valid` = 1 in the cycle after every accept, otherwise 0. No back-pressure: the consumer always accepts.
- With `in_valid` = 1 every cycle, throughput is one symbol per cycle.
- A `sync` cycle produces `out_valid` = 0 in the following cycle. The first post-sync symbol can be accepted in the cycle after `sync`.
- On assertion of `reset`, asynchronously:
  - `out_valid` = 0, `out_data` = 0, `select` = 0, `primed` = 0;
  - all FIFO cells = 0 and the accept counter = 0;
  - the mode register takes the value of `mode`.
- A reset during streaming discards all in-flight data. Output after release matches the post-reset sequence.
- A `mode` change without `sync` or reset has no effect.

## Test plan
- **Interleave, default parameters (B=4, S=1)**: feed in_data = 1, 2, 3, … every cycle from reset release.
  - `out_data` = 1,0,0,0, 5,2,0,0, 9,6,3,0, 13,10,7,4, 17,14,11,8.
  - `select` cycles 0,1,2,3.
  - `primed` rises with the output of index 15, whose value is 4.
- **Deinterleave, same stimulus**: `out_data` = 0,0,0,4, 0,0,3,8, 0,2,7,12, 1,6,11,16, 5,10,15,20.
  - `primed` rises at index 15, whose value is 16.
- **Cascade interleave → deinterleave, stream 1, 2, 3, …**: the first 12 outputs are 0; then outputs are 1, 2, 3, … contiguous.
  - Repeat with B=8, S=2: outputs are 0 for 112 symbols, then 1, 2, ….
- **Stall**: drop `in_valid` for 3 cycles after every 5th symbol.
  - The output symbol sequence is identical to the no-stall run.
  - `out_valid` is low exactly in the cycles following the idle cycles.
  - `select` holds its value during stalls.
- **Sync mid-stream**: pulse `sync` at symbol 7 with `mode` = 1.
  - `select` returns to 0 and `primed` drops.
  - Subsequent outputs follow the deinterleave branch delays.
- **Reset mid-stream**: assert `reset` at symbol 9.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the sequence reproduces the first scenario exactly.
